bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_to_bin_seq_if.sv | 24 ++
 rtl/bcd_digit_fix.sv | 11 +
 rtl/bcd_to_bin_seq.sv | 116 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helpers for the BCD-to-binary converter.
package bcd_pkg;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] DD_THRESH     = 4'd8;
  localparam logic [3:0] DD_CORR       = 4'd3;

  // state | meaning
  // IDLE  | waiting for an input word, in_ready high
  // CONV  | shifting one binary bit per clock, busy high
  // DONE  | result (or error) presented, out_valid high until accepted
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Input/output handshake bundle for the BCD-to-binary converter.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err, busy
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err, busy
  );
endinterface

// File: rtl/bcd_digit_fix.sv
// Reverse double-dabble digit correction: a digit that reached 8 or more after the shift gets 3 removed.
module bcd_digit_fix
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= DD_THRESH) ? (d_i - DD_CORR) : d_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter, one result bit per clock.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;

  state_e             state_q;
  logic [WORK_W-1:0]  work_q;
  logic [WORK_W-1:0]  work_d;
  logic [WORK_W-1:0]  shifted;
  logic [BCD_W-1:0]   fixed_bcd;
  logic [CNT_W-1:0]   count_q;
  logic [BIN_W-1:0]   bin_q;
  logic               err_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               in_legal;

  // The shifted BCD half is corrected digit by digit in parallel.
  assign shifted = work_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_fix
    bcd_digit_fix u_fix (
      .d_i (shifted[BIN_W + 4*g +: 4]),
      .d_o (fixed_bcd[4*g +: 4])
    );
  end

  assign work_d = {fixed_bcd, shifted[BIN_W-1:0]};

  // Whole-word legality: every digit must be 0..9.
  always_comb begin
    in_legal = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(bus.bcd_in[4*i +: 4])) in_legal = 1'b0;
    end
  end

  // Control FSM with registered handshake outputs and the shift datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      count_q     <= '0;
      bin_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            if (!in_legal) begin
              // Illegal digits skip conversion entirely and report at once.
              err_q       <= 1'b1;
              bin_q       <= '0;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              work_q  <= {bus.bcd_in, {BIN_W{1'b0}}};
              count_q <= '0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          work_q  <= work_d;
          count_q <= count_q + 1'b1;
          if (count_q == CNT_W'(BIN_W - 1)) begin
            // Every legal input leaves nothing in the BCD half after the last shift.
            assert (work_d[WORK_W-1:BIN_W] == '0);
            bin_q       <= work_d[BIN_W-1:0];
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bin_out   = bin_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for the BCD-to-binary converter.
module tb_bcd_to_bin_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  bcd_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus ();

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word for exactly one accept edge (caller ensures in_ready is high).
  task automatic accept(input logic [15:0] bcd);
    bus.bcd_in   = bcd;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.bcd_in    = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.bin_out !== 14'd0) begin n_bad++; $display("FAIL reset_bin_out: got %0d want 0", bus.bin_out); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_zero();
    int cycles;
    accept(16'h0000);
    cycles = 0;
    while (!bus.out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    n_cmp++; if (cycles !== 14) begin n_bad++; $display("FAIL zero_latency: got %0d cycles want 14", cycles); end
    n_cmp++; if (bus.bin_out !== 14'd0) begin n_bad++; $display("FAIL zero_bin: got %0d want 0", bus.bin_out); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL zero_err: got %b want 0", bus.err); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL zero_handshake_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_handshake_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_max();
    int cycles;
    int busy_cnt;
    accept(16'h9999);
    cycles   = 0;
    busy_cnt = 0;
    while (!bus.out_valid && cycles < 40) begin
      if (bus.busy) busy_cnt++;
      tick();
      cycles++;
    end
    n_cmp++; if (busy_cnt !== 14) begin n_bad++; $display("FAIL max_busy_cycles: got %0d want 14", busy_cnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL max_busy_at_done: got %b want 0", bus.busy); end
    n_cmp++; if (bus.bin_out !== 14'h270F) begin n_bad++; $display("FAIL max_bin: got %0h want 270f", bus.bin_out); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL max_err: got %b want 0", bus.err); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int cycles;
    accept(16'h1234);
    cycles = 0;
    while (!bus.out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.bin_out !== 14'h04D2 || bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got valid=%b bin=%0h err=%b in_ready=%b want 1/4d2/0/0",
                 i, bus.out_valid, bus.bin_out, bus.err, bus.in_ready);
      end
      tick();
    end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.bin_out !== 14'h04D2) begin n_bad++; $display("FAIL stall_sixth: got valid=%b bin=%0h want 1/4d2", bus.out_valid, bus.bin_out); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.bin_out !== 14'h04D2) begin n_bad++; $display("FAIL stall_bin_kept: got %0h want 4d2", bus.bin_out); end
  endtask

  task automatic test_illegal();
    accept(16'h00A5);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL illegal_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL illegal_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.bin_out !== 14'd0) begin n_bad++; $display("FAIL illegal_bin: got %0h want 0", bus.bin_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL illegal_busy: got %b want 0", bus.busy); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.err !== 1'b1 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_after: got err=%b in_ready=%b want 1/1", bus.err, bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    int cycles;
    int seen_valid;
    accept(16'h0500);
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.bin_out !== 14'd0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_state: got valid=%b bin=%0h in_ready=%b busy=%b err=%b want 0/0/1/0/0",
               bus.out_valid, bus.bin_out, bus.in_ready, bus.busy, bus.err);
    end
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) seen_valid++;
      tick();
    end
    n_cmp++; if (seen_valid !== 0) begin n_bad++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen_valid); end
    // Reset and in_valid together: nothing may be captured.
    rst          = 1'b1;
    bus.bcd_in   = 16'h0007;
    bus.in_valid = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_vs_valid: got in_ready=%b busy=%b valid=%b want 1/0/0", bus.in_ready, bus.busy, bus.out_valid);
    end
    accept(16'h0042);
    cycles = 0;
    while (!bus.out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.bin_out !== 14'd42) begin n_bad++; $display("FAIL midrst_next: got valid=%b bin=%0d want 1/42", bus.out_valid, bus.bin_out); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int          cyc;
    int          n_acc;
    int          n_res;
    int          acc_edge [2];
    logic [13:0] res [2];
    cyc         = 0;
    n_acc       = 0;
    n_res       = 0;
    acc_edge[0] = 0;
    acc_edge[1] = 0;
    res[0]      = '0;
    res[1]      = '0;
    bus.bcd_in    = 16'h0001;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (n_res < 2 && cyc < 100) begin
      if (bus.out_valid) begin
        res[n_res] = bus.bin_out;
        n_res++;
      end
      if (bus.in_ready && bus.in_valid && n_acc < 2) begin
        acc_edge[n_acc] = cyc + 1;
        n_acc++;
      end
      tick();
      cyc++;
      if (n_acc == 1) bus.bcd_in = 16'h0010;
      if (n_acc == 2) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++; if (n_res !== 2) begin n_bad++; $display("FAIL b2b_results: got %0d results want 2", n_res); end
    n_cmp++; if (res[0] !== 14'd1) begin n_bad++; $display("FAIL b2b_first: got %0d want 1", res[0]); end
    n_cmp++; if (res[1] !== 14'd10) begin n_bad++; $display("FAIL b2b_second: got %0d want 10", res[1]); end
    n_cmp++; if (acc_edge[1] - acc_edge[0] !== 16) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 16", acc_edge[1] - acc_edge[0]); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_zero();
    test_max();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
